tow_round_ctrl: RTL and testbench

Round sequencer for the tug-of-war game. Sits between the debounced push-buttons and the rope-position FSM in `top`. Each round it runs a pseudo-random wait, raises the go light, and picks the first player to press, breaking same-cycle ties round-robin. It penalises presses made before the light ("jumping the light"), pulses one rope move into the position FSM, clears it, and stops when the FSM reports a win.

---
 rtl/tow_round_ctrl.sv | 154 +++++++++++++++
 tb/tb_tow_round_ctrl.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tow_round_ctrl.sv
// Tug-of-war round sequencer: random pre-light wait, go light, first-press
// arbitration with round-robin tie break, false-start penalty and per-round clear.
module tow_round_ctrl #(
    parameter int unsigned WAIT_MIN   = 4,
    parameter logic [7:0]  WAIT_MASK  = 8'h07,
    parameter int unsigned CLR_CYCLES = 2,
    parameter int unsigned GO_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic pbl,
    input  logic pbr,
    input  logic win,
    output logic leds_on,
    output logic mvl,
    output logic mvr,
    output logic foul,
    output logic clr,
    output logic busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_DELAY,
        S_GO,
        S_HIT,
        S_CLEAR,
        S_DONE
    } state_t;

    localparam logic [15:0] WAIT_MIN_W = 16'(WAIT_MIN);
    localparam logic [15:0] CLR_W      = 16'(CLR_CYCLES);
    localparam logic [15:0] GO_W       = 16'(GO_TIMEOUT);

    state_t      state;
    logic [15:0] cnt;
    logic [7:0]  lfsr;
    logic        prio;
    logic        lfsr_fb;
    logic [15:0] wait_load;

    // x^8 + x^6 + x^5 + x^4 + 1, shifted towards the MSB
    assign lfsr_fb   = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
    assign wait_load = WAIT_MIN_W + {8'h00, lfsr & WAIT_MASK};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr <= 8'hA5;
        end else begin
            lfsr <= {lfsr[6:0], lfsr_fb};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            prio    <= 1'b0;
            leds_on <= 1'b0;
            mvl     <= 1'b0;
            mvr     <= 1'b0;
            foul    <= 1'b0;
            clr     <= 1'b0;
            busy    <= 1'b0;
        end else begin
            // move/foul are single-cycle pulses by default
            mvl  <= 1'b0;
            mvr  <= 1'b0;
            foul <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state <= S_ARM;
                        busy  <= 1'b1;
                    end
                end
                S_ARM: begin
                    if (!pbl && !pbr) begin
                        cnt   <= wait_load;
                        state <= S_DELAY;
                    end
                end
                S_DELAY: begin
                    cnt <= cnt - 16'd1;
                    if (pbl && pbr) begin
                        foul  <= 1'b1;
                        clr   <= 1'b1;
                        cnt   <= CLR_W;
                        state <= S_CLEAR;
                    end else if (pbl) begin
                        mvr   <= 1'b1;
                        foul  <= 1'b1;
                        state <= S_HIT;
                    end else if (pbr) begin
                        mvl   <= 1'b1;
                        foul  <= 1'b1;
                        state <= S_HIT;
                    end else if (cnt == 16'd1) begin
                        cnt     <= GO_W;
                        leds_on <= 1'b1;
                        state   <= S_GO;
                    end
                end
                S_GO: begin
                    cnt <= cnt - 16'd1;
                    if (pbl || pbr) begin
                        leds_on <= 1'b0;
                        state   <= S_HIT;
                        if (pbl && pbr) begin
                            // tie: prio side (0 = left) takes the move, then alternate
                            mvl  <= ~prio;
                            mvr  <= prio;
                            prio <= ~prio;
                        end else begin
                            mvl <= pbl;
                            mvr <= pbr;
                        end
                    end else if (cnt == 16'd1) begin
                        leds_on <= 1'b0;
                        clr     <= 1'b1;
                        cnt     <= CLR_W;
                        state   <= S_CLEAR;
                    end
                end
                S_HIT: begin
                    clr   <= 1'b1;
                    cnt   <= CLR_W;
                    state <= S_CLEAR;
                end
                S_CLEAR: begin
                    cnt <= cnt - 16'd1;
                    if (cnt == 16'd1) begin
                        clr <= 1'b0;
                        if (win) begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                        end else begin
                            state <= S_ARM;
                        end
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    leds_on <= 1'b0;
                    clr     <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tow_round_ctrl.sv
// Testbench for tow_round_ctrl: directed and randomized rounds checked against
// a round-outcome model plus an LFSR-based prediction of the pre-light wait.
module tb_tow_round_ctrl;

    localparam int          WAIT_MIN   = 4;
    localparam logic [7:0]  WAIT_MASK  = 8'h07;
    localparam int          CLR_CYCLES = 2;
    localparam int          GO_TIMEOUT = 16;

    logic clk = 1'b0;
    logic rst, start, pbl, pbr, win;
    logic leds_on, mvl, mvr, foul, clr, busy;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [7:0] lfsr_m;
    logic       prio_m;
    logic       in_arm, pending;
    int         pred;
    logic       busy_q, clr_q, leds_q;

    tow_round_ctrl #(
        .WAIT_MIN  (WAIT_MIN),
        .WAIT_MASK (WAIT_MASK),
        .CLR_CYCLES(CLR_CYCLES),
        .GO_TIMEOUT(GO_TIMEOUT)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .pbl    (pbl),
        .pbr    (pbr),
        .win    (win),
        .leds_on(leds_on),
        .mvl    (mvl),
        .mvr    (mvr),
        .foul   (foul),
        .clr    (clr),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // new bit is the parity of tap positions 8,6,5,4
    function automatic logic [7:0] next_lfsr(input logic [7:0] x);
        return {x[6:0], ^(x & 8'hB8)};
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) lfsr_m <= 8'hA5;
        else      lfsr_m <= next_lfsr(lfsr_m);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs on negedges: predicts the go-light edge from the ARM exit and the LFSR.
    task automatic mon_step();
        if (!rst) begin
            in_arm  = 1'b0;
            pending = 1'b0;
        end else begin
            if ((busy && !busy_q) || (clr_q && !clr && busy)) in_arm = 1'b1;
            if (in_arm && !pbl && !pbr) begin
                pred    = cyc + 1 + WAIT_MIN + int'(lfsr_m & WAIT_MASK);
                in_arm  = 1'b0;
                pending = 1'b1;
            end
            if (leds_on && !leds_q) begin
                check("wait_len", pending ? cyc : -1, pred);
                pending = 1'b0;
            end
            if (clr && !clr_q) pending = 1'b0;
            check("mv_excl", {31'd0, mvl & mvr}, 0);
        end
        busy_q = busy;
        clr_q  = clr;
        leds_q = leds_on;
    endtask

    task automatic wait_leds();
        int g = 0;
        while (!leds_on && g < 400) begin tick(); g++; end
        if (!leds_on) check("leds_timeout", 0, 1);
    endtask

    task automatic wait_delay();
        int g = 0;
        while (!pending && g < 400) begin tick(); g++; end
        if (!pending) check("delay_timeout", 0, 1);
    endtask

    task automatic clear_tail(input int held0, input int hold, input logic exp_done);
        int   held = held0;
        int   n = 0;
        logic bad = 1'b0;
        while (clr && n < 50) begin
            if (mvl || mvr || leds_on || (foul && n > 0)) bad = 1'b1;
            n++;
            if (held >= hold) begin pbl = 1'b0; pbr = 1'b0; end
            tick();
            held++;
        end
        check("clr_len", n, CLR_CYCLES);
        check("clr_quiet", {31'd0, bad}, 0);
        check("post_clr_busy", {31'd0, busy}, {31'd0, ~exp_done});
        while (held < hold) begin
            check("arm_hold", {busy, leds_on, mvl, mvr}, 4'b1000);
            tick();
            held++;
        end
        pbl = 1'b0;
        pbr = 1'b0;
    endtask

    task automatic press(input logic l, input logic r, input logic [2:0] exp_mmf,
                         input int hold, input logic exp_done);
        pbl = l;
        pbr = r;
        tick();
        if (exp_mmf[2:1] != 2'b00) begin
            check("hit_mv_foul", {mvl, mvr, foul}, exp_mmf);
            check("hit_leds_clr", {leds_on, clr}, 2'b00);
            if (hold <= 1) begin pbl = 1'b0; pbr = 1'b0; end
            tick();
            clear_tail(2, hold, exp_done);
        end else begin
            check("dbl_foul", {mvl, mvr, foul, clr, leds_on}, 5'b00110);
            clear_tail(1, hold, exp_done);
        end
    endtask

    task automatic go_exp(input logic l, input logic r, output logic [2:0] e);
        if (l && r) begin
            e      = prio_m ? 3'b010 : 3'b100;
            prio_m = ~prio_m;
        end else begin
            e = {l, r, 1'b0};
        end
    endtask

    // false start: the other player gets the move; both pressing is a foul only
    function automatic logic [2:0] delay_exp(input logic l, input logic r);
        if (l && r) return 3'b001;
        return {r, l, 1'b1};
    endfunction

    task automatic go_round(input logic l, input logic r, input int dly, input int hold,
                            input logic set_win, input logic exp_done);
        logic [2:0] e;
        wait_leds();
        repeat (dly) tick();
        if (set_win) win = 1'b1;
        go_exp(l, r, e);
        press(l, r, e, hold, exp_done);
    endtask

    task automatic delay_round(input logic l, input logic r, input int d);
        int g = 0;
        wait_delay();
        if (d < 0) begin
            // press lands on the last wait cycle
            while (cyc + 1 < pred && g < 50) begin tick(); g++; end
        end else begin
            repeat (d) tick();
        end
        press(l, r, delay_exp(l, r), 1, 1'b0);
    endtask

    task automatic idle_round();
        int   n = 0;
        logic mv = 1'b0;
        wait_leds();
        while (leds_on && n < 100) begin
            if (mvl || mvr) mv = 1'b1;
            n++;
            tick();
        end
        check("leds_len", n, GO_TIMEOUT);
        check("go_nomove", {31'd0, mv}, 0);
        clear_tail(0, 0, 1'b0);
    endtask

    initial begin
        int k;
        rst    = 1'b0;
        start  = 1'b0;
        pbl    = 1'b0;
        pbr    = 1'b0;
        win    = 1'b0;
        prio_m = 1'b0;
        in_arm = 1'b0;
        pending = 1'b0;
        pred   = 0;
        busy_q = 1'b0;
        clr_q  = 1'b0;
        leds_q = 1'b0;
        fork
            forever begin @(negedge clk); mon_step(); end
            begin
                #1000000;
                $display("FAIL watchdog: simulation did not finish");
                $fatal(1, "watchdog expired");
            end
        join_none

        repeat (3) tick();
        check("rst_outs", {leds_on, mvl, mvr, foul, clr, busy}, 0);
        rst = 1'b1;
        repeat (2) tick();
        check("idle_busy", {31'd0, busy}, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_busy", {31'd0, busy}, 1);

        idle_round();
        go_round(1'b1, 1'b0, 3, 2, 1'b0, 1'b0);
        go_round(1'b1, 1'b0, 0, 6, 1'b0, 1'b0);
        delay_round(1'b0, 1'b1, 0);
        delay_round(1'b1, 1'b0, -1);
        delay_round(1'b1, 1'b1, 1);

        go_round(1'b1, 1'b1, 0, 1, 1'b0, 1'b0);
        go_round(1'b1, 1'b1, 15, 1, 1'b0, 1'b0);
        go_round(1'b1, 1'b1, int'($urandom_range(1, 14)), 1, 1'b0, 1'b0);

        for (int i = 0; i < 10; i++) begin
            k = int'($urandom_range(0, 6));
            case (k)
                0: idle_round();
                1: go_round(1'b1, 1'b0, int'($urandom_range(0, 15)), int'($urandom_range(1, 4)), 1'b0, 1'b0);
                2: go_round(1'b0, 1'b1, int'($urandom_range(0, 15)), int'($urandom_range(1, 4)), 1'b0, 1'b0);
                3: go_round(1'b1, 1'b1, int'($urandom_range(0, 15)), int'($urandom_range(1, 4)), 1'b0, 1'b0);
                4: delay_round(1'b1, 1'b0, int'($urandom_range(0, 3)));
                5: delay_round(1'b0, 1'b1, int'($urandom_range(0, 3)));
                default: delay_round(1'b1, 1'b1, int'($urandom_range(0, 3)));
            endcase
        end

        go_round(1'b0, 1'b1, 2, 1, 1'b0, 1'b0);
        go_round(1'b1, 1'b0, 4, 1, 1'b1, 1'b1);
        repeat (3) tick();
        check("done_hold", {busy, leds_on, clr, mvl, mvr, foul}, 0);
        start = 1'b1;
        win   = 1'b0;
        tick();
        start = 1'b0;
        check("restart_busy", {31'd0, busy}, 1);

        wait_leds();
        pbl = 1'b1;
        tick();
        pbl = 1'b0;
        check("pre_rst_hit", {31'd0, mvl}, 1);
        tick();
        check("pre_rst_clr", {31'd0, clr}, 1);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst", {leds_on, mvl, mvr, foul, clr, busy}, 0);
        tick();
        rst    = 1'b1;
        prio_m = 1'b0;
        repeat (3) tick();
        check("post_rst_idle", {leds_on, mvl, mvr, foul, clr, busy}, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        go_round(1'b1, 1'b1, 5, 1, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
